// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-bus bundle between the fetch controller and instruction memory.
//   pc       : current fetch address, driven by the fetch controller
//   ce       : instruction memory chip enable, driven by the fetch controller
//   ibus_req : fetch request valid, driven by the fetch controller
//   ibus_ack : memory has returned data for the current pc, driven by memory
// The master modport is the fetch controller; the slave modport is memory.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic        ce;
  logic        ibus_req;
  logic        ibus_ack;

  modport master (
    output pc,
    output ce,
    output ibus_req,
    input  ibus_ack
  );

  modport slave (
    input  pc,
    input  ce,
    input  ibus_req,
    output ibus_ack
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Program-counter sequencer and pipeline stall generator for the fetch stage.
// Ports:
//   clk           : sole clock, rising edge
//   rst           : asynchronous active-low reset
//   stallreq_id   : decode stage requests a stall
//   stallreq_ex   : execute stage requests a stall
//   branch_flag   : resolved taken branch this cycle
//   branch_target : branch destination address
//   flush         : exception/flush redirect
//   new_pc        : flush destination address
//   ibus          : instruction bus (pc, ce, ibus_req out; ibus_ack in)
//   stall         : per-stage hold vector {wb,mem,ex,id,if,pc}, combinational
//   ibus_timeout  : sticky flag, memory failed to acknowledge within TIMEOUT
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallreq_id,
  input  logic          stallreq_ex,
  input  logic          branch_flag,
  input  logic [31:0]   branch_target,
  input  logic          flush,
  input  logic [31:0]   new_pc,
  fetch_ctrl_if.master  ibus,
  output logic [5:0]    stall,
  output logic          ibus_timeout
);

  // Counter is at least 5 bits but grows if TIMEOUT needs more.
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   pc_q;
  logic [31:0]   pc_next;
  logic          ce_q;
  logic          req_q;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_next;
  logic          timeout_next;

  // Redirect addresses are word aligned, so their low bits are never used.
  logic unused_low_bits;
  assign unused_low_bits = ^{new_pc[1:0], branch_target[1:0]};

  assign ibus.pc       = pc_q;
  assign ibus.ce       = ce_q;
  assign ibus.ibus_req = req_q;

  // Next-state, stall vector, next pc and wait-counter logic.
  // The stall vector is computed first because both the state transition
  // and the pc hold decision depend on stall[0]. A taken branch seen while
  // stall[0] is high is dropped; the branching stage is itself held and
  // presents the branch again once the pipeline moves.
  always_comb begin
    state_next   = state;
    stall        = 6'b000000;
    pc_next      = pc_q;
    wait_next    = wait_cnt;
    timeout_next = ibus_timeout;

    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ, HOLD: begin
        if (flush) begin
          stall = 6'b000000;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (ce_q && !ibus.ibus_ack) begin
          stall = 6'b000011;
        end

        state_next = (stall[0] && !flush) ? HOLD : REQ;

        if (flush) begin
          pc_next = {new_pc[31:2], 2'b00};
        end else if (stall[0]) begin
          pc_next = pc_q;
        end else if (branch_flag) begin
          pc_next = {branch_target[31:2], 2'b00};
        end else begin
          pc_next = pc_q + 32'd4;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The wait count measures how long the current pc has gone unacknowledged.
    if (state == IDLE || ibus.ibus_ack || pc_next != pc_q) begin
      wait_next = '0;
    end else if (ce_q && wait_cnt != TMAX) begin
      wait_next = wait_cnt + 1'b1;
    end

    if (wait_next == TMAX) begin
      timeout_next = 1'b1;
    end
  end

  // State, pc, bus strobes, wait counter and sticky timeout registers.
  // Reset abandons any request in flight; the first edge after release only
  // moves IDLE to REQ, so pc is not incremented on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      ce_q         <= 1'b0;
      req_q        <= 1'b0;
      wait_cnt     <= '0;
      ibus_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      pc_q         <= pc_next;
      ce_q         <= (state_next != IDLE);
      req_q        <= (state_next != IDLE);
      wait_cnt     <= wait_next;
      ibus_timeout <= timeout_next;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A behavioural model tracks what pc,
// ce, ibus_req, stall and ibus_timeout must be and a compare process checks
// the DUT against it on every falling clock edge. Directed scenarios also
// check hand-computed literal values at key points.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'h0;
  logic [5:0]  stall;
  logic        ibus_timeout;

  int total = 0;
  int bad   = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .ibus          (bus),
    .stall         (stall),
    .ibus_timeout  (ibus_timeout)
  );

  always #5 clk = ~clk;

  // Model state: whether fetching has started since reset, the current
  // address, how many cycles the current address has waited, and the flag.
  logic        m_active = 1'b0;
  logic [31:0] m_pc     = RESET_PC;
  int          m_wait   = 0;
  logic        m_to     = 1'b0;

  // The pc may not advance when any stage below it is held or memory has not
  // answered, unless a flush overrides everything.
  function automatic logic pc_held();
    return !flush && (stallreq_ex || stallreq_id || !bus.ibus_ack);
  endfunction

  function automatic logic [5:0] exp_stall();
    if (!m_active)   return 6'b000000;
    if (flush)       return 6'b000000;
    if (stallreq_ex) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    if (!bus.ibus_ack) return 6'b000011;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] model_next_pc();
    if (!m_active)  return m_pc;
    if (flush)      return new_pc & 32'hFFFF_FFFC;
    if (pc_held())  return m_pc;
    if (branch_flag) return branch_target & 32'hFFFF_FFFC;
    return m_pc + 32'd4;
  endfunction

  function automatic int model_next_wait();
    if (!m_active || bus.ibus_ack || model_next_pc() != m_pc) return 0;
    return (m_wait < TIMEOUT) ? m_wait + 1 : TIMEOUT;
  endfunction

  // Model update on each rising edge, reset asynchronously like the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_pc     <= RESET_PC;
      m_wait   <= 0;
      m_to     <= 1'b0;
    end else begin
      m_active <= 1'b1;
      m_pc     <= model_next_pc();
      m_wait   <= model_next_wait();
      m_to     <= m_to | (model_next_wait() >= TIMEOUT);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    checkOutput("cmp_pc", bus.pc, m_pc);
    checkOutput("cmp_ce", {31'b0, bus.ce}, {31'b0, m_active});
    checkOutput("cmp_req", {31'b0, bus.ibus_req}, {31'b0, m_active});
    checkOutput("cmp_stall", {26'b0, stall}, {26'b0, exp_stall()});
    checkOutput("cmp_timeout", {31'b0, ibus_timeout}, {31'b0, m_to});
  end

  task automatic applyStimulus(input logic id, input logic ex, input logic br,
                               input logic [31:0] tgt, input logic fl,
                               input logic [31:0] npc, input logic ack);
    stallreq_id   = id;
    stallreq_ex   = ex;
    branch_flag   = br;
    branch_target = tgt;
    flush         = fl;
    new_pc        = npc;
    bus.ibus_ack  = ack;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_pc", bus.pc, 32'h0);
    checkOutput("reset_ce", {31'b0, bus.ce}, 32'h0);
    checkOutput("reset_req", {31'b0, bus.ibus_req}, 32'h0);
    checkOutput("reset_to", {31'b0, ibus_timeout}, 32'h0);
    tick(2);
    rst = 1'b1;
    #1 checkOutput("idle_ce", {31'b0, bus.ce}, 32'h0);

    // Free-running sequencing with ack tied high.
    tick(1);
    checkOutput("first_ce", {31'b0, bus.ce}, 32'h1);
    checkOutput("first_pc", bus.pc, 32'h0);
    tick(1); checkOutput("seq_pc4", bus.pc, 32'h4);
    tick(1); checkOutput("seq_pc8", bus.pc, 32'h8);
    tick(1); checkOutput("seq_pcC", bus.pc, 32'hC);
    checkOutput("seq_stall", {26'b0, stall}, 32'h0);
    tick(1); checkOutput("seq_pc10", bus.pc, 32'h10);

    // Memory wait for three cycles.
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    #1 checkOutput("wait_stall", {26'b0, stall}, 32'h03);
    tick(3);
    checkOutput("wait_pc_hold", bus.pc, 32'h10);
    checkOutput("wait_no_to", {31'b0, ibus_timeout}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(1); checkOutput("wait_pc14", bus.pc, 32'h14);

    // Execute stall hides a branch; branch re-presented after release.
    applyStimulus(0, 1, 1, 32'h100, 0, 32'h0, 1);
    #1 checkOutput("ex_stall", {26'b0, stall}, 32'h0F);
    tick(2); checkOutput("ex_pc_hold", bus.pc, 32'h14);
    applyStimulus(0, 0, 1, 32'h100, 0, 32'h0, 1);
    tick(1); checkOutput("branch_pc", bus.pc, 32'h100);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(1); checkOutput("branch_pc_next", bus.pc, 32'h104);

    // Flush beats branch and aligns the address.
    applyStimulus(0, 0, 1, 32'h40, 1, 32'h2000_0183, 1);
    #1 checkOutput("flush_stall", {26'b0, stall}, 32'h0);
    tick(1); checkOutput("flush_pc", bus.pc, 32'h2000_0180);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(1); checkOutput("flush_pc_next", bus.pc, 32'h2000_0184);

    // Wrap from the top of the address space.
    applyStimulus(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
    tick(1); checkOutput("wrap_top", bus.pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(1); checkOutput("wrap_zero", bus.pc, 32'h0);
    tick(1); checkOutput("wrap_four", bus.pc, 32'h4);

    // Missing acknowledge for TIMEOUT cycles sets the sticky flag.
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick(TIMEOUT - 1);
    checkOutput("to_not_yet", {31'b0, ibus_timeout}, 32'h0);
    tick(1);
    checkOutput("to_set", {31'b0, ibus_timeout}, 32'h1);
    checkOutput("to_pc_hold", bus.pc, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(1);
    checkOutput("to_sticky", {31'b0, ibus_timeout}, 32'h1);
    checkOutput("to_pc8", bus.pc, 32'h8);
    tick(1); checkOutput("to_pcC", bus.pc, 32'hC);

    // Asynchronous reset in the middle of a decode stall.
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 1);
    #1 checkOutput("id_stall", {26'b0, stall}, 32'h07);
    tick(2); checkOutput("id_pc_hold", bus.pc, 32'hC);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_pc", bus.pc, 32'h0);
    checkOutput("arst_ce", {31'b0, bus.ce}, 32'h0);
    checkOutput("arst_req", {31'b0, bus.ibus_req}, 32'h0);
    checkOutput("arst_to", {31'b0, ibus_timeout}, 32'h0);
    checkOutput("arst_stall", {26'b0, stall}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
    tick(2);
    rst = 1'b1;
    #1 checkOutput("rel_ce", {31'b0, bus.ce}, 32'h0);
    tick(1);
    checkOutput("rel_first_ce", {31'b0, bus.ce}, 32'h1);
    checkOutput("rel_first_pc", bus.pc, 32'h0);
    tick(1); checkOutput("rel_pc4", bus.pc, 32'h4);
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
